// File: rtl/drive_pkg.sv
// Shared definitions for the H-bridge drive stage: state encoding, default
// sizing and small helpers used by the controller.
package drive_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FWD   = 2'b01,
        BWD   = 2'b10,
        COAST = 2'b11
    } state_t;

    localparam int DEF_PWM_BITS     = 8;
    localparam int DEF_DEADTIME_CYC = 1000;
    localparam int DEAD_CNT_BITS    = 16;

    function automatic logic is_driving(input state_t s);
        return (s == FWD) || (s == BWD);
    endfunction

    function automatic logic fwd_exit(input logic fwd_req, input logic bwd_req,
                                      input logic stop_f);
        return stop_f | ~fwd_req | bwd_req;
    endfunction

    function automatic logic bwd_exit(input logic fwd_req, input logic bwd_req,
                                      input logic stop_b);
        return stop_b | ~bwd_req | fwd_req;
    endfunction

endpackage

// File: rtl/drive_pwm_gen.sv
// Free-running PWM generator. The duty word is latched only at the counter
// wrap so a period is never cut short or stretched mid-way.
module pwm_gen
    import drive_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_raw,
    output logic                o_pwm_next
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1'b1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_lat;
    logic [PWM_BITS-1:0] w_cnt_next;
    logic [PWM_BITS-1:0] w_duty_lat_next;

    // Next counter/latch values; the compare on them is what the output flops load.
    always_comb begin
        w_cnt_next = r_pwm_cnt + CNT_ONE;
        if (r_pwm_cnt == CNT_MAX) begin
            w_duty_lat_next = i_duty;
        end else begin
            w_duty_lat_next = r_duty_lat;
        end
        o_pwm_raw  = (r_pwm_cnt < r_duty_lat);
        o_pwm_next = (w_cnt_next < w_duty_lat_next);
    end

    // Counter and duty latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_duty_lat <= '0;
        end else begin
            r_pwm_cnt  <= w_cnt_next;
            r_duty_lat <= w_duty_lat_next;
        end
    end

endmodule

// File: rtl/drive_ctrl.sv
// H-bridge drive controller: direction FSM with an enforced coast interval on
// every exit from a driving state, gated PWM onto the two bridge legs.
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int DEADTIME_CYC = DEF_DEADTIME_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fwd_req,
    input  logic                bwd_req,
    input  logic                stop_f,
    input  logic                stop_b,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_a,
    output logic                pwm_b,
    output logic                moving,
    output logic [1:0]          state_o
);

    localparam logic [DEAD_CNT_BITS-1:0] DEAD_LOAD = DEAD_CNT_BITS'(DEADTIME_CYC - 1);
    localparam logic [DEAD_CNT_BITS-1:0] DEAD_ONE  = DEAD_CNT_BITS'(1'b1);
    localparam logic [DEAD_CNT_BITS-1:0] DEAD_ZERO = DEAD_CNT_BITS'(1'b0);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [DEAD_CNT_BITS-1:0] r_dead_cnt;
    logic [DEAD_CNT_BITS-1:0] w_dead_cnt_next;

    logic w_pwm_raw;
    logic w_pwm_next;
    logic w_pwm_a_next;
    logic w_pwm_b_next;
    logic w_moving_next;

    logic r_pwm_a;
    logic r_pwm_b;
    logic r_moving;

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk        (clk),
        .rst        (rst),
        .i_duty     (duty),
        .o_pwm_raw  (w_pwm_raw),
        .o_pwm_next (w_pwm_next)
    );

    // State register and dead-time counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dead_cnt <= DEAD_ZERO;
        end else begin
            r_state    <= w_next_state;
            r_dead_cnt <= w_dead_cnt_next;
        end
    end

    // Next-state logic; a reversal must always pass through COAST and IDLE.
    always_comb begin
        w_next_state    = r_state;
        w_dead_cnt_next = r_dead_cnt;
        case (r_state)
            IDLE: begin
                if (fwd_req && !bwd_req && !stop_f) begin
                    w_next_state = FWD;
                end else if (bwd_req && !fwd_req && !stop_b) begin
                    w_next_state = BWD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FWD: begin
                if (fwd_exit(fwd_req, bwd_req, stop_f)) begin
                    w_next_state    = COAST;
                    w_dead_cnt_next = DEAD_LOAD;
                end else begin
                    w_next_state = FWD;
                end
            end
            BWD: begin
                if (bwd_exit(fwd_req, bwd_req, stop_b)) begin
                    w_next_state    = COAST;
                    w_dead_cnt_next = DEAD_LOAD;
                end else begin
                    w_next_state = BWD;
                end
            end
            COAST: begin
                if (r_dead_cnt == DEAD_ZERO) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state    = COAST;
                    w_dead_cnt_next = r_dead_cnt - DEAD_ONE;
                end
            end
            default: begin
                w_next_state    = IDLE;
                w_dead_cnt_next = DEAD_ZERO;
            end
        endcase
    end

    // Output decode from next state, so the legs react on the same edge as the FSM.
    always_comb begin
        w_pwm_a_next  = (w_next_state == FWD) & w_pwm_next;
        w_pwm_b_next  = (w_next_state == BWD) & w_pwm_next;
        w_moving_next = is_driving(w_next_state);
    end

    // Registered outputs; reset drops both legs at once with no coast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_a  <= 1'b0;
            r_pwm_b  <= 1'b0;
            r_moving <= 1'b0;
        end else begin
            r_pwm_a  <= w_pwm_a_next;
            r_pwm_b  <= w_pwm_b_next;
            r_moving <= w_moving_next;
        end
    end

    assign pwm_a   = r_pwm_a;
    assign pwm_b   = r_pwm_b;
    assign moving  = r_moving;
    assign state_o = r_state;

    // Current-cycle PWM level is only of interest in simulation views.
    logic w_unused;
    assign w_unused = w_pwm_raw;

endmodule

// File: tb/tb_drive_ctrl.sv
// Self-checking bench for drive_ctrl: directed scenarios followed by random
// stimulus, all compared each cycle against a cycle-level behavioural model.
module tb_drive_ctrl;

    localparam int PW     = 4;
    localparam int DT     = 4;
    localparam int PERIOD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fwd_req;
    logic          bwd_req;
    logic          stop_f;
    logic          stop_b;
    logic [PW-1:0] duty;
    logic          pwm_a;
    logic          pwm_b;
    logic          moving;
    logic [1:0]    state_o;

    drive_ctrl #(
        .PWM_BITS     (PW),
        .DEADTIME_CYC (DT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fwd_req (fwd_req),
        .bwd_req (bwd_req),
        .stop_f  (stop_f),
        .stop_b  (stop_b),
        .duty    (duty),
        .pwm_a   (pwm_a),
        .pwm_b   (pwm_b),
        .moving  (moving),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: mode 0 idle, 1 forward, 2 backward, 3 coasting; m_left = coast cycles still owed.
    int m_cnt  = 0;
    int m_lat  = 0;
    int m_mode = 0;
    int m_left = 0;

    int hi;
    int n_coast;
    int last_a;
    int first_b;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_cnt  = 0;
            m_lat  = 0;
            m_mode = 0;
            m_left = 0;
        end else begin
            if (m_cnt == PERIOD - 1) m_lat = int'(duty);
            m_cnt = (m_cnt + 1) % PERIOD;
            case (m_mode)
                0: begin
                    if (fwd_req && !bwd_req && !stop_f) m_mode = 1;
                    else if (bwd_req && !fwd_req && !stop_b) m_mode = 2;
                end
                1: if (stop_f || !fwd_req || bwd_req) begin m_mode = 3; m_left = DT; end
                2: if (stop_b || !bwd_req || fwd_req) begin m_mode = 3; m_left = DT; end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("state_o", 8'(state_o), 8'(m_mode));
        check("pwm_a", 8'(pwm_a), 8'(m_mode == 1 && m_cnt < m_lat));
        check("pwm_b", 8'(pwm_b), 8'(m_mode == 2 && m_cnt < m_lat));
        check("moving", 8'(moving), 8'(m_mode == 1 || m_mode == 2));
        check("no_shoot_through", 8'(pwm_a & pwm_b), 8'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; fwd_req = 1'b0; bwd_req = 1'b0;
        stop_f = 1'b0; stop_b = 1'b0; duty = 4'd0;
        run(2);
        check("reset_outputs", 8'({pwm_a, pwm_b, moving, state_o}), 8'd0);

        // Forward at half duty; first period low.
        rst = 1'b0; fwd_req = 1'b1; duty = 4'd8;
        tick();
        check("fwd_entry_latency", 8'(state_o), 8'd1);
        hi = 0;
        for (int i = 0; i < 14; i++) begin tick(); hi += int'(pwm_a); end
        check("first_period_low", 8'(hi), 8'd0);
        run(48);
        hi = 0;
        for (int i = 0; i < 16; i++) begin tick(); hi += int'(pwm_a); end
        check("duty8_highs", 8'(hi), 8'd8);

        // One-cycle stop_f pulse.
        stop_f = 1'b1;
        tick();
        stop_f = 1'b0;
        check("stop_same_edge", 8'({state_o, pwm_a, moving}), 8'b0000_1100);
        n_coast = 1;
        for (int i = 0; i < 10 && state_o == 2'b11; i++) begin
            tick();
            if (state_o == 2'b11) n_coast++;
        end
        check("coast_len", 8'(n_coast), 8'(DT));
        check("idle_after_coast", 8'(state_o), 8'd0);
        tick();
        check("refwd", 8'(state_o), 8'd1);

        // Reversal forward -> backward.
        for (int i = 0; i < 20 && !pwm_a; i++) tick();
        check("pre_rev_a_high", 8'(pwm_a), 8'd1);
        last_a = cyc; first_b = -1;
        fwd_req = 1'b0; bwd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pwm_a) last_a = cyc;
            if (pwm_b && first_b < 0) first_b = cyc;
        end
        check("rev_gap", 8'(first_b >= 0 && (first_b - last_a) >= 6), 8'd1);

        // Duty extremes in BWD.
        duty = 4'd0;
        run(20);
        hi = 0;
        for (int i = 0; i < 16; i++) begin tick(); hi += int'(pwm_b); end
        check("duty0_highs", 8'(hi), 8'd0);
        duty = 4'd15;
        run(20);
        hi = 0;
        for (int i = 0; i < 16; i++) begin tick(); hi += int'(pwm_b); end
        check("duty15_highs", 8'(hi), 8'd15);

        // IDLE refusals and stop_b ignored in FWD.
        bwd_req = 1'b0;
        run(8);
        fwd_req = 1'b1; bwd_req = 1'b1;
        run(5);
        check("both_req_idle", 8'({state_o, pwm_a, pwm_b}), 8'd0);
        bwd_req = 1'b0; stop_f = 1'b1;
        run(5);
        check("stop_f_blocks_idle", 8'({state_o, pwm_a, pwm_b}), 8'd0);
        stop_f = 1'b0; stop_b = 1'b1;
        run(20);
        check("fwd_ignores_stop_b", 8'(state_o), 8'd1);
        stop_b = 1'b0;

        // Reset mid-PWM-high in BWD, then mid-COAST.
        fwd_req = 1'b0; bwd_req = 1'b1;
        run(10);
        for (int i = 0; i < 20 && !pwm_b; i++) tick();
        check("pre_rst_b_high", 8'(pwm_b), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_bwd", 8'({pwm_a, pwm_b, moving, state_o}), 8'd0);
        hi = 0;
        for (int i = 0; i < 15; i++) begin tick(); hi += int'(pwm_b); end
        check("post_rst_period_low", 8'(hi), 8'd0);
        bwd_req = 1'b0;
        run(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_coast", 8'({pwm_a, pwm_b, moving, state_o}), 8'd0);

        // Random phase.
        for (int i = 0; i < 500; i++) begin
            rst     = ($urandom_range(0, 149) == 0);
            fwd_req = ($urandom_range(0, 9) < 6);
            bwd_req = ($urandom_range(0, 9) < 3);
            stop_f  = ($urandom_range(0, 9) == 0);
            stop_b  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) duty = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
